// File: rtl/nchan_rr_mux_pkg.sv
// Shared definitions for the N-channel round-robin / fixed-select output mux.
// Mode encodings are used by the top level when choosing the grant source.
package nchan_rr_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/nchan_rr_mux_rr_pick.sv
// Rotating priority search: first requester strictly after ptr, wrapping,
// with ptr itself checked last.
module rr_pick #(
  parameter  int CH = 4,
  localparam int SW = $clog2(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic          found,
  output logic [SW-1:0] idx
);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise paths that skip the assignment infer a latch.
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= CH; k++) begin
      if (!found && req[(int'(ptr) + k) % CH]) begin
        found = 1'b1;
        idx   = SW'((int'(ptr) + k) % CH);
      end
    end
  end

endmodule

// File: rtl/nchan_rr_mux.sv
// CH-channel mux into a single-entry registered output stage, selecting
// either a fixed channel (sel) or a round-robin rotating grant.
module nchan_rr_mux
  import nchan_rr_mux_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int CH = 4,
  localparam int SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  output logic [N-1:0]    out_data,
  output logic [SW-1:0]   out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [SW-1:0] ptr;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic          fix_found;
  logic          grant_found;
  logic [SW-1:0] grant_idx;
  logic [N-1:0]  grant_data;
  logic          load_en;
  logic          ch_xfer;
  logic          rr_mode;

  rr_pick #(.CH(CH)) u_rr_pick (
    .req   (in_valid),
    .ptr   (ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  assign rr_mode = (mode_e'(mode) == MODE_RR);

  // An out-of-range sel never grants, even for non-power-of-two CH.
  always_comb begin
    fix_found = 1'b0;
    if (int'(sel) < CH) fix_found = in_valid[sel];
  end

  always_comb begin
    grant_found = fix_found;
    grant_idx   = sel;
    if (rr_mode) begin
      grant_found = rr_found;
      grant_idx   = rr_idx;
    end
  end

  assign grant_data = in_data[int'(grant_idx)*N +: N];

  // The output register accepts a new beat when empty or draining this edge.
  assign load_en = !out_valid || out_ready;
  assign ch_xfer = grant_found && load_en && !rst;

  always_comb begin
    in_ready = '0;
    if (ch_xfer) in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SW'(CH - 1);
    end else if (ch_xfer) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_chan  <= grant_idx;
      if (rr_mode) ptr <= grant_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nchan_rr_mux.sv
// Directed bench for nchan_rr_mux: a vector table for single-cycle behaviour
// plus hand-written multi-cycle sequences (rotation, stall, async reset).
module tb_nchan_rr_mux;

  localparam int N  = 8;
  localparam int CH = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;

  int total = 0;
  int bad   = 0;

  nchan_rr_mux #(.N(N), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            mode;
    logic [SW-1:0]   sel;
    logic [CH-1:0]   vld;
    logic [CH*N-1:0] data;
    logic            ordy;
    logic [CH-1:0]   exp_rdy;
    logic            exp_ov;
    logic [N-1:0]    exp_od;
    logic [SW-1:0]   exp_oc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic ov, input logic [N-1:0] od,
                           input logic [SW-1:0] oc);
    check({name, ".valid"}, 32'(out_valid), 32'(ov));
    check({name, ".data"},  32'(out_data),  32'(od));
    check({name, ".chan"},  32'(out_chan),  32'(oc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = '0;
    @(negedge clk);
    check("reset.in_ready", 32'(in_ready), 32'h0);
    check_out("reset", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
  endtask

  // Channel i carries 8'h10 + i in the sequences.
  localparam logic [CH*N-1:0] SEQ_DATA = 32'h13121110;

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b0;

    //        mode sel  vld      data          ordy exp_rdy  ov    od     oc
    vecs[0]  = '{1'b0, 2'd2, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[1]  = '{1'b0, 2'd0, 4'b0001, 32'h0000005A, 1'b1, 4'b0001, 1'b1, 8'h5A, 2'd0};
    vecs[2]  = '{1'b0, 2'd3, 4'b1000, 32'hC3000000, 1'b0, 4'b0000, 1'b1, 8'h5A, 2'd0};
    vecs[3]  = '{1'b0, 2'd3, 4'b1000, 32'hC3000000, 1'b1, 4'b1000, 1'b1, 8'hC3, 2'd3};
    vecs[4]  = '{1'b0, 2'd1, 4'b1101, 32'h44332211, 1'b1, 4'b0000, 1'b0, 8'hC3, 2'd3};
    vecs[5]  = '{1'b0, 2'd1, 4'b1101, 32'h44332211, 1'b0, 4'b0000, 1'b0, 8'hC3, 2'd3};
    vecs[6]  = '{1'b1, 2'd0, 4'b0110, 32'h00887700, 1'b0, 4'b0010, 1'b1, 8'h77, 2'd1};
    vecs[7]  = '{1'b1, 2'd0, 4'b0110, 32'h00887700, 1'b1, 4'b0100, 1'b1, 8'h88, 2'd2};
    vecs[8]  = '{1'b0, 2'd0, 4'b0001, 32'h00000099, 1'b1, 4'b0001, 1'b1, 8'h99, 2'd0};
    vecs[9]  = '{1'b1, 2'd0, 4'b1111, 32'hDDCCBBAA, 1'b1, 4'b1000, 1'b1, 8'hDD, 2'd3};
    vecs[10] = '{1'b1, 2'd0, 4'b0001, 32'h000000E0, 1'b1, 4'b0001, 1'b1, 8'hE0, 2'd0};
    vecs[11] = '{1'b1, 2'd0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'hE0, 2'd0};

    #2;
    check("por.in_ready", 32'(in_ready), 32'h0);
    check_out("por", 1'b0, 8'h00, 2'd0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      mode      = vecs[i].mode;
      sel       = vecs[i].sel;
      in_valid  = vecs[i].vld;
      in_data   = vecs[i].data;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_oc);
    end

    // Full rotation with every channel valid.
    do_reset();
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b1111; in_data = SEQ_DATA; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("rot%0d", k), 1'b1, 8'(8'h10 + (k % CH)), SW'(k % CH));
    end

    // Sparse requesters: only channels 1 and 3 ever granted.
    do_reset();
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b1010; in_data = SEQ_DATA; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("sparse%0d.in_ready", k), 32'(in_ready), (k == 1) ? 32'h8 : 32'h2);
      @(posedge clk);
      #1;
      check_out($sformatf("sparse%0d", k), 1'b1, (k == 1) ? 8'h13 : 8'h11, (k == 1) ? 2'd3 : 2'd1);
      @(negedge clk);
    end

    // Downstream stall holds the beat, then drain and reload on one edge.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d.in_ready", k), 32'(in_ready), 32'h0);
      @(posedge clk);
      #1;
      check_out($sformatf("stall%0d", k), 1'b1, 8'h11, 2'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("drain.in_ready", 32'(in_ready), 32'h8);
    @(posedge clk);
    #1;
    check_out("drain", 1'b1, 8'h13, 2'd3);

    // Asynchronous reset between edges, then a fresh round-robin grant.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.in_ready", 32'(in_ready), 32'h0);
    check_out("async_rst", 1'b0, 8'h00, 2'd0);
    @(negedge clk);
    rst = 1'b0; mode = 1'b1; in_valid = 4'b0110; out_ready = 1'b1;
    #1;
    check("post_rst.in_ready", 32'(in_ready), 32'h2);
    @(posedge clk);
    #1;
    check_out("post_rst", 1'b1, 8'h11, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
